// File: rtl/cnn_conv_pool_top_if.sv
// DRAM-side bus of the conv/pool layer engine: ifmap read port, filter/bias
// configuration and pooled-result write port.
interface cnn_conv_pool_top_if;
  logic [63:0] ifmap;
  logic [71:0] filter;
  logic [15:0] bias;
  logic        DRAMreadEn;
  logic [9:0]  DRAMreadAddr;
  logic        DRAMwriteEn;
  logic [9:0]  DRAMwriteAddr;
  logic [63:0] DRAMwriteData;

  // Engine side: consumes read data and configuration, drives DRAM requests
  modport master (
    input  ifmap, filter, bias,
    output DRAMreadEn, DRAMreadAddr, DRAMwriteEn, DRAMwriteAddr, DRAMwriteData
  );

  // Memory side: returns read data and configuration, observes requests
  modport slave (
    output ifmap, filter, bias,
    input  DRAMreadEn, DRAMreadAddr, DRAMwriteEn, DRAMwriteAddr, DRAMwriteData
  );
endinterface

// File: rtl/cnn_conv_pool_top.sv
// Single-channel CNN layer engine: loads a square 8-bit ifmap from DRAM, runs a
// 3x3 zero-padded conv + bias + ReLU + requantise, 2x2 max-pools the result and
// writes the packed pooled map back to DRAM. One conv output per cycle.
// Optional feature macro: CLOCK_GATE_EN (latch-based clock gates on the conv
// datapath/pack registers and on the ifmap buffer instead of enable muxes).
module cnn_conv_pool_top #(
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned SHIFT     = 7,
  parameter int unsigned DONE_ADDR = 25
) (
  input logic                 clk,
  input logic                 rst,
  cnn_conv_pool_top_if.master bus
);

  localparam int unsigned POOL_W = IMG_W / 2;
  localparam int unsigned NPIX   = IMG_W * IMG_W;
  localparam int unsigned NWORDS = NPIX / 8;
  localparam int unsigned NPOOL  = POOL_W * POOL_W;
  localparam int unsigned BUF_AW = $clog2(NWORDS);
  localparam int unsigned P_W    = $clog2(NPOOL);
  localparam int unsigned RC_W   = $clog2(POOL_W);
  localparam int unsigned ACC_W  = 22;
  localparam int unsigned AW     = 10;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CONV, ST_FLUSH, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic                    rd_en_q, rd_en_d;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [63:0]             wr_data_q, wr_data_d;
  logic                    pend_q, pend_d;
  logic [AW-1:0]           pend_addr_q, pend_addr_d;
  logic [71:0]             filt_q, filt_d;
  logic signed [15:0]      bias_q, bias_d;

  logic [RC_W-1:0]         r_q, r_d, c_q, c_d;
  logic [1:0]              q_q, q_d;
  logic [P_W-1:0]          p_q, p_d;
  logic [7:0]              max_q, max_d;
  logic [63:0]             word_q, word_d;

  logic [63:0]             buf_q [NWORDS];

  logic signed [ACC_W-1:0] acc_c, sh_c;
  logic [7:0]              y_c, mx_c;
  logic [63:0]             word_ins_c;
  logic                    conv_en_c, load_en_c;
  logic                    conv_clk, load_clk, conv_upd, load_upd;

  assign conv_en_c = (state_q == ST_CONV) || (state_q == ST_FLUSH);
  assign load_en_c = (state_q == ST_LOAD);

`ifdef CLOCK_GATE_EN
  logic conv_lat, load_lat;

  // Enables captured while clk is low so the gated clocks cannot glitch
  always_latch begin
    if (!clk) begin
      conv_lat <= conv_en_c;
      load_lat <= load_en_c;
    end
  end

  assign conv_clk = clk & conv_lat;
  assign load_clk = clk & load_lat;
  assign conv_upd = 1'b1;
  assign load_upd = 1'b1;
`else
  assign conv_clk = clk;
  assign load_clk = clk;
  assign conv_upd = conv_en_c;
  assign load_upd = load_en_c;
`endif

  // One conv output per cycle: 9 parallel MACs, bias, ReLU, shift and saturate
  always_comb begin
    int tr, tc, idx;
    logic [63:0]       wd;
    logic [7:0]        px;
    logic signed [7:0] wt;
    tr    = 0;
    tc    = 0;
    idx   = 0;
    wd    = '0;
    px    = '0;
    wt    = '0;
    acc_c = ACC_W'(bias_q);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        tr  = 2 * int'(r_q) + int'(q_q[1]) + i - 1;
        tc  = 2 * int'(c_q) + int'(q_q[0]) + j - 1;
        idx = 0;
        wd  = '0;
        px  = '0;
        if (tr >= 0 && tr < int'(IMG_W) && tc >= 0 && tc < int'(IMG_W)) begin
          idx = tr * int'(IMG_W) + tc;
          wd  = buf_q[BUF_AW'(idx / 8)];
          px  = 8'(wd >> (8 * (idx % 8)));
        end
        wt    = 8'(filt_q >> (8 * (8 - (3 * i + j))));
        acc_c = acc_c + ACC_W'($signed({1'b0, px})) * ACC_W'(wt);
      end
    end
    sh_c = acc_c >>> SHIFT;
    if (acc_c < 0) begin
      y_c = 8'd0;
    end else if (sh_c > ACC_W'(255)) begin
      y_c = 8'd255;
    end else begin
      y_c = sh_c[7:0];
    end
    mx_c = ((q_q == 2'd0) || (y_c > max_q)) ? y_c : max_q;
  end

  // Next-state and registered-output logic for the load/conv/flush sequence
  always_comb begin
    state_d     = state_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    pend_d      = rd_en_q;
    pend_addr_d = rd_addr_q;
    filt_d      = filt_q;
    bias_d      = bias_q;
    r_d         = r_q;
    c_d         = c_q;
    q_d         = q_q;
    p_d         = p_q;
    max_d       = max_q;
    word_d      = word_q;
    word_ins_c  = word_q | (64'(mx_c) << {p_q[2:0], 3'b000});
    case (state_q)
      ST_IDLE: begin
        state_d   = ST_LOAD;
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
      end
      ST_LOAD: begin
        if (rd_en_q && (rd_addr_q != AW'(NWORDS - 1))) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + AW'(1);
        end
        if (pend_q && (pend_addr_q == AW'(NWORDS - 1))) begin
          state_d = ST_CONV;
          filt_d  = bus.filter;
          bias_d  = bus.bias;
        end
      end
      ST_CONV: begin
        max_d = mx_c;
        q_d   = q_q + 2'd1;
        if (q_q == 2'd3) begin
          if (p_q[2:0] == 3'd7) begin
            wr_en_d   = 1'b1;
            wr_addr_d = AW'(p_q[P_W-1:3]);
            wr_data_d = word_ins_c;
            word_d    = '0;
          end else begin
            word_d = word_ins_c;
          end
          if (p_q == P_W'(NPOOL - 1)) begin
            state_d = (p_q[2:0] == 3'd7) ? ST_DONE : ST_FLUSH;
          end else begin
            p_d = p_q + P_W'(1);
            if (c_q == RC_W'(POOL_W - 1)) begin
              c_d = '0;
              r_d = r_q + RC_W'(1);
            end else begin
              c_d = c_q + RC_W'(1);
            end
          end
        end
      end
      ST_FLUSH: begin
        wr_en_d   = 1'b1;
        wr_addr_d = AW'(p_q[P_W-1:3]);
        wr_data_d = word_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        wr_addr_d = AW'(DONE_ADDR);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, DRAM-facing outputs, read-return pipeline and captured config
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      filt_q      <= '0;
      bias_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      filt_q      <= filt_d;
      bias_q      <= bias_d;
    end
  end

  // Conv scan counters, pooling max and output packing word
  always_ff @(posedge conv_clk or negedge rst) begin
    if (!rst) begin
      r_q    <= '0;
      c_q    <= '0;
      q_q    <= '0;
      p_q    <= '0;
      max_q  <= '0;
      word_q <= '0;
    end else if (conv_upd) begin
      r_q    <= r_d;
      c_q    <= c_d;
      q_q    <= q_d;
      p_q    <= p_d;
      max_q  <= max_d;
      word_q <= word_d;
    end
  end

  // Ifmap buffer: read data lands one cycle after the request is seen by DRAM
  always_ff @(posedge load_clk) begin
    if (load_upd && pend_q) begin
      buf_q[BUF_AW'(pend_addr_q)] <= bus.ifmap;
    end
  end

  assign bus.DRAMreadEn    = rd_en_q;
  assign bus.DRAMreadAddr  = rd_addr_q;
  assign bus.DRAMwriteEn   = wr_en_q;
  assign bus.DRAMwriteAddr = wr_addr_q;
  assign bus.DRAMwriteData = wr_data_q;

endmodule

// File: tb/tb_cnn_conv_pool_top.sv
// Bench for cnn_conv_pool_top: DRAM model with one-cycle read latency, write
// logger, and a direct-arithmetic conv/ReLU/pool reference model.
module tb_cnn_conv_pool_top;
  localparam int NIN = 98, NOUT = 25, NPOOL = 196, DONE_A = 25;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cnn_conv_pool_top_if bus();

  cnn_conv_pool_top dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] mem [NIN];
  int          wr_addr_log [$];
  logic [63:0] wr_data_log [$];
  int          n_overlap = 0;
  int          n_early = 0;
  int          exp_pool [NPOOL];
  int          n_cmp = 0;
  int          n_mis = 0;

  // DRAM read port (registered, one-cycle latency) and write/protocol monitor
  always @(posedge clk) begin
    if (bus.DRAMreadEn) bus.ifmap <= mem[7'(bus.DRAMreadAddr)];
    if (rst) begin
      if (bus.DRAMwriteEn) begin
        wr_addr_log.push_back(int'(bus.DRAMwriteAddr));
        wr_data_log.push_back(bus.DRAMwriteData);
      end
      if (bus.DRAMreadEn && bus.DRAMwriteEn) n_overlap <= n_overlap + 1;
      if (bus.DRAMwriteAddr == 10'(DONE_A) && wr_addr_log.size() < NOUT) n_early <= n_early + 1;
    end
  end

  // Reference: direct 3x3 conv with zero padding, ReLU, >>7 with clamp, 2x2 max
  task automatic compute_expected(input logic [71:0] f, input logic [15:0] b);
    int img [784];
    int wts [9];
    int acc, y, m;
    logic [63:0] wv;
    for (int i = 0; i < 784; i++) begin
      wv = mem[i / 8];
      img[i] = int'(8'(wv >> (8 * (i % 8))));
    end
    for (int k = 0; k < 9; k++) wts[k] = int'($signed(f[71 - 8 * k -: 8]));
    for (int r = 0; r < 14; r++) begin
      for (int c = 0; c < 14; c++) begin
        m = 0;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            acc = int'($signed(b));
            for (int i = 0; i < 3; i++) begin
              for (int j = 0; j < 3; j++) begin
                int yy, xx;
                yy = 2 * r + dy + i - 1;
                xx = 2 * c + dx + j - 1;
                if (yy >= 0 && yy < 28 && xx >= 0 && xx < 28) acc += img[yy * 28 + xx] * wts[i * 3 + j];
              end
            end
            y = (acc < 0) ? 0 : ((acc / 128 > 255) ? 255 : acc / 128);
            if (y > m) m = y;
          end
        end
        exp_pool[r * 14 + c] = m;
      end
    end
  endtask

  function automatic logic [63:0] exp_word(input int w);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      if (w * 8 + b < NPOOL) r[8 * b +: 8] = 8'(exp_pool[w * 8 + b]);
    end
    return r;
  endfunction

  function automatic logic [63:0] got_word(input int w);
    logic [63:0] r;
    r = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int k = 0; k < wr_addr_log.size(); k++) if (wr_addr_log[k] == w) r = wr_data_log[k];
    return r;
  endfunction

  task automatic start_run();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    wr_addr_log.delete();
    wr_data_log.delete();
    rst = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bus.DRAMwriteAddr == 10'(DONE_A)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.DRAMreadEn !== 1'b0) begin n_mis++; $display("FAIL reset_readEn got %b want 0", bus.DRAMreadEn); end
    n_cmp++; if (bus.DRAMreadAddr !== 10'd0) begin n_mis++; $display("FAIL reset_readAddr got %0d want 0", bus.DRAMreadAddr); end
    n_cmp++; if (bus.DRAMwriteEn !== 1'b0) begin n_mis++; $display("FAIL reset_writeEn got %b want 0", bus.DRAMwriteEn); end
    n_cmp++; if (bus.DRAMwriteAddr !== 10'd0) begin n_mis++; $display("FAIL reset_writeAddr got %0d want 0", bus.DRAMwriteAddr); end
    n_cmp++; if (bus.DRAMwriteData !== 64'd0) begin n_mis++; $display("FAIL reset_writeData got %h want 0", bus.DRAMwriteData); end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.DRAMreadEn !== 1'b1 || bus.DRAMreadAddr !== 10'(k)) begin
        n_mis++; $display("FAIL load_seq%0d got en=%b addr=%0d want en=1 addr=%0d", k, bus.DRAMreadEn, bus.DRAMreadAddr, k);
      end
    end
  endtask

  task automatic test_bias_only();
    bit ok;
    logic [63:0] g;
    for (int i = 0; i < NIN; i++) mem[i] = '0;
    bus.filter = '0;
    bus.bias = 16'h01CB;
    compute_expected(bus.filter, bus.bias);
    start_run();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL bias_done got timeout want addr %0d", DONE_A); end
    for (int w = 0; w < NOUT; w++) begin
      g = got_word(w);
      n_cmp++; if (g !== exp_word(w)) begin n_mis++; $display("FAIL bias_word%0d got %h want %h", w, g, exp_word(w)); end
    end
    g = got_word(0);
    n_cmp++; if (g !== {8{8'h03}}) begin n_mis++; $display("FAIL bias_word0_const got %h want 0303030303030303", g); end
    g = got_word(24);
    n_cmp++; if (g !== 64'h0000_0000_0303_0303) begin n_mis++; $display("FAIL bias_word24_const got %h want 0000000003030303", g); end
  endtask

  task automatic test_identity();
    bit ok;
    logic [63:0] g;
    for (int i = 0; i < NIN; i++) mem[i] = '1;
    bus.filter = 72'h00_00_00_00_01_00_00_00_00;
    bus.bias = 16'h0000;
    compute_expected(bus.filter, bus.bias);
    start_run();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL ident_done got timeout want addr %0d", DONE_A); end
    for (int w = 0; w < NOUT; w++) begin
      g = got_word(w);
      n_cmp++; if (g !== exp_word(w)) begin n_mis++; $display("FAIL ident_word%0d got %h want %h", w, g, exp_word(w)); end
    end
    g = got_word(5);
    n_cmp++; if (g !== {8{8'h01}}) begin n_mis++; $display("FAIL ident_word5_const got %h want 0101010101010101", g); end
  endtask

  task automatic test_saturation();
    bit ok;
    logic [63:0] g;
    for (int i = 0; i < NIN; i++) mem[i] = '1;
    bus.filter = {9{8'h7F}};
    bus.bias = 16'h0000;
    compute_expected(bus.filter, bus.bias);
    start_run();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL sat_done got timeout want addr %0d", DONE_A); end
    for (int w = 0; w < NOUT; w++) begin
      g = got_word(w);
      n_cmp++; if (g !== exp_word(w)) begin n_mis++; $display("FAIL sat_word%0d got %h want %h", w, g, exp_word(w)); end
    end
    g = got_word(24);
    n_cmp++; if (g !== 64'h0000_0000_FFFF_FFFF) begin n_mis++; $display("FAIL sat_word24_const got %h want 00000000FFFFFFFF", g); end
  endtask

  task automatic test_relu_writes();
    bit ok;
    int ov0, ea0;
    logic [63:0] g;
    for (int i = 0; i < NIN; i++) mem[i] = {$urandom, $urandom};
    bus.filter = {9{8'h80}};
    bus.bias = 16'h0000;
    ov0 = n_overlap;
    ea0 = n_early;
    start_run();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL relu_done got timeout want addr %0d", DONE_A); end
    for (int w = 0; w < NOUT; w++) begin
      g = got_word(w);
      n_cmp++; if (g !== 64'd0) begin n_mis++; $display("FAIL relu_word%0d got %h want 0", w, g); end
    end
    n_cmp++; if (wr_addr_log.size() != NOUT) begin n_mis++; $display("FAIL relu_nwrites got %0d want %0d", wr_addr_log.size(), NOUT); end
    for (int k = 0; k < wr_addr_log.size(); k++) begin
      n_cmp++; if (wr_addr_log[k] != k) begin n_mis++; $display("FAIL relu_order%0d got addr %0d want %0d", k, wr_addr_log[k], k); end
    end
    n_cmp++; if (n_overlap != ov0) begin n_mis++; $display("FAIL relu_overlap got %0d want 0", n_overlap - ov0); end
    n_cmp++; if (n_early != ea0) begin n_mis++; $display("FAIL relu_early_done got %0d want 0", n_early - ea0); end
  endtask

  task automatic test_random();
    bit ok;
    int d, ov0, ea0;
    logic [63:0] g;
    for (int i = 0; i < NIN; i++) mem[i] = {$urandom, $urandom};
    bus.filter = 72'hF9_ED_1A_0D_F1_F4_10_0A_F1;
    bus.bias = 16'h01CB;
    compute_expected(bus.filter, bus.bias);
    ov0 = n_overlap;
    ea0 = n_early;
    start_run();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL rand_done got timeout want addr %0d", DONE_A); end
    for (int p = 0; p < NPOOL; p++) begin
      g = got_word(p / 8);
      d = int'(8'(g >> (8 * (p % 8)))) - exp_pool[p];
      n_cmp++; if (d > 1 || d < -1) begin
        n_mis++; $display("FAIL rand_pix%0d got %0d want %0d", p, int'(8'(g >> (8 * (p % 8)))), exp_pool[p]);
      end
    end
    g = got_word(24);
    n_cmp++; if (g[63:32] !== 32'd0) begin n_mis++; $display("FAIL rand_word24_pad got %h want 0", g[63:32]); end
    repeat (20) @(negedge clk);
    n_cmp++; if (bus.DRAMwriteAddr !== 10'(DONE_A) || bus.DRAMwriteEn !== 1'b0 || bus.DRAMreadEn !== 1'b0) begin
      n_mis++; $display("FAIL rand_done_hold got addr=%0d wen=%b ren=%b want addr=%0d wen=0 ren=0",
                        bus.DRAMwriteAddr, bus.DRAMwriteEn, bus.DRAMreadEn, DONE_A);
    end
    n_cmp++; if (n_overlap != ov0 || n_early != ea0) begin
      n_mis++; $display("FAIL rand_protocol got overlap=%0d early=%0d want 0 0", n_overlap - ov0, n_early - ea0);
    end
  endtask

  task automatic test_reset_mid_conv();
    bit ok;
    logic [63:0] g;
    for (int i = 0; i < NIN; i++) mem[i] = {$urandom, $urandom};
    bus.filter = 72'hF9_ED_1A_0D_F1_F4_10_0A_F1;
    bus.bias = 16'h01CB;
    compute_expected(bus.filter, bus.bias);
    start_run();
    repeat (400) @(negedge clk);
    n_cmp++; if (bus.DRAMwriteAddr === 10'(DONE_A)) begin n_mis++; $display("FAIL midrst_running got addr %0d want < %0d", bus.DRAMwriteAddr, DONE_A); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.DRAMwriteEn !== 1'b0 || bus.DRAMwriteAddr !== 10'd0 || bus.DRAMreadEn !== 1'b0 || bus.DRAMwriteData !== 64'd0) begin
      n_mis++; $display("FAIL midrst_outputs got wen=%b waddr=%0d ren=%b wdata=%h want all 0",
                        bus.DRAMwriteEn, bus.DRAMwriteAddr, bus.DRAMreadEn, bus.DRAMwriteData);
    end
    start_run();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL midrst_done got timeout want addr %0d", DONE_A); end
    for (int w = 0; w < NOUT; w++) begin
      g = got_word(w);
      n_cmp++; if (g !== exp_word(w)) begin n_mis++; $display("FAIL midrst_word%0d got %h want %h", w, g, exp_word(w)); end
    end
    n_cmp++; if (wr_addr_log.size() != NOUT) begin n_mis++; $display("FAIL midrst_nwrites got %0d want %0d", wr_addr_log.size(), NOUT); end
  endtask

  initial begin
    bus.filter = '0;
    bus.bias = '0;
    bus.ifmap = '0;
    for (int i = 0; i < NIN; i++) mem[i] = '0;
    test_reset();
    test_bias_only();
    test_identity();
    test_saturation();
    test_relu_writes();
    test_random();
    test_reset_mid_conv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
